// File: rtl/motion_diff_threshold_if.sv
// Stream bundle between the background/current input FIFOs, the output FIFO
// and the difference stage. The stage connects through the slave modport.
interface motion_diff_threshold_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int LANES       = 4
);
  localparam int WORD_WIDTH = LANES * PIXEL_WIDTH;

  // Input side: two show-ahead FIFOs popped in lockstep.
  logic                  in_empty;
  logic [WORD_WIDTH-1:0] in_bg_dout;
  logic [WORD_WIDTH-1:0] in_cur_dout;
  logic                  in_rd_en;

  // Output side.
  logic                  out_full;
  logic                  out_wr_en;
  logic [WORD_WIDTH-1:0] out_din;

  modport master (
    output in_empty, in_bg_dout, in_cur_dout, out_full,
    input  in_rd_en, out_wr_en, out_din
  );

  modport slave (
    input  in_empty, in_bg_dout, in_cur_dout, out_full,
    output in_rd_en, out_wr_en, out_din
  );
endinterface

// File: rtl/motion_diff_threshold.sv
// Multi-lane background subtraction: |cur - bg| per lane, emitted as a binary
// mask or raw magnitude, with a per-frame motion-pixel count.
module motion_diff_threshold #(
  parameter int PIXEL_WIDTH = 8,
  parameter int LANES       = 4,
  parameter int FRAME_WORDS = 97200,
  parameter int CNT_WIDTH   = $clog2(FRAME_WORDS * LANES + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PIXEL_WIDTH-1:0] threshold,
  input  logic                   mode,
  motion_diff_threshold_if.slave bus,
  output logic                   frame_done,
  output logic [CNT_WIDTH-1:0]   motion_count
);

  localparam int WORD_WIDTH = LANES * PIXEL_WIDTH;
  localparam int IDX_WIDTH  = $clog2(FRAME_WORDS);
  localparam int POP_WIDTH  = $clog2(LANES + 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_WORDS - 1);

  // Result register and frame bookkeeping.
  logic                   valid_q;
  logic [WORD_WIDTH-1:0]  data_q;
  logic [POP_WIDTH-1:0]   pop_q;
  logic [IDX_WIDTH-1:0]   cap_idx;
  logic [IDX_WIDTH-1:0]   wr_idx;
  logic [CNT_WIDTH-1:0]   acc;
  logic [PIXEL_WIDTH-1:0] thr_q;
  logic                   mode_q;

  logic                   accept;
  logic                   push;
  logic                   frame_start;
  logic [PIXEL_WIDTH-1:0] thr_eff;
  logic                   mode_eff;
  logic [PIXEL_WIDTH-1:0] lane_diff [LANES];
  logic [LANES-1:0]       lane_motion;
  logic [WORD_WIDTH-1:0]  data_next;
  logic [POP_WIDTH-1:0]   pop_next;

  // Holding reset low also holds the pop low, even with data waiting.
  assign accept = reset && !bus.in_empty && (!valid_q || !bus.out_full);
  assign push   = valid_q && !bus.out_full;

  assign bus.in_rd_en  = accept;
  assign bus.out_wr_en = push;
  assign bus.out_din   = data_q;

  // The first word of a frame already uses the freshly latched settings.
  assign frame_start = (cap_idx == '0);
  assign thr_eff     = frame_start ? threshold : thr_q;
  assign mode_eff    = frame_start ? mode : mode_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [PIXEL_WIDTH-1:0] bg_px;
    logic [PIXEL_WIDTH-1:0] cur_px;
    logic [PIXEL_WIDTH:0]   delta;

    assign bg_px  = bus.in_bg_dout[g*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign cur_px = bus.in_cur_dout[g*PIXEL_WIDTH +: PIXEL_WIDTH];
    // One extra bit keeps the sign, so the magnitude never wraps.
    assign delta  = {1'b0, cur_px} - {1'b0, bg_px};
    assign lane_diff[g]   = delta[PIXEL_WIDTH] ? PIXEL_WIDTH'(-delta)
                                               : delta[PIXEL_WIDTH-1:0];
    assign lane_motion[g] = (lane_diff[g] > thr_eff);
    assign data_next[g*PIXEL_WIDTH +: PIXEL_WIDTH] =
      mode_eff ? lane_diff[g] : {PIXEL_WIDTH{lane_motion[g]}};
  end

  always_comb begin
    // NOTE: assign a default before the loop so no path leaves pop_next unassigned (no latch).
    pop_next = '0;
    for (int i = 0; i < LANES; i++) begin
      pop_next = pop_next + POP_WIDTH'(lane_motion[i]);
    end
  end

  // Capture side: result register, capture index and latched settings.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pop_q   <= '0;
      cap_idx <= '0;
      thr_q   <= '0;
      mode_q  <= 1'b0;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      valid_q <= 1'b1;
      data_q  <= data_next;
      pop_q   <= pop_next;
      cap_idx <= (cap_idx == LAST_IDX) ? '0 : cap_idx + 1'b1;
      if (frame_start) begin
        thr_q  <= threshold;
        mode_q <= mode;
      end
    end else if (push) begin
      valid_q <= 1'b0;
    end
  end

  // Write side: push index, motion accumulator and frame report.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_idx       <= '0;
      acc          <= '0;
      motion_count <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (push) begin
        if (wr_idx == LAST_IDX) begin
          wr_idx       <= '0;
          acc          <= '0;
          motion_count <= acc + CNT_WIDTH'(pop_q);
          frame_done   <= 1'b1;
        end else begin
          wr_idx <= wr_idx + 1'b1;
          acc    <= acc + CNT_WIDTH'(pop_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_motion_diff_threshold.sv
// Directed plus randomized checks of motion_diff_threshold against a
// queue-based reference model of the input/output FIFO traffic.
module tb_motion_diff_threshold;

  localparam int PW     = 8;
  localparam int LANES  = 4;
  localparam int FW     = 2;
  localparam int W      = PW * LANES;
  localparam int CNT_W  = $clog2(FW * LANES + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [PW-1:0]    threshold;
  logic             mode;
  logic             frame_done;
  logic [CNT_W-1:0] motion_count;

  motion_diff_threshold_if #(.PIXEL_WIDTH(PW), .LANES(LANES)) bus ();

  motion_diff_threshold #(
    .PIXEL_WIDTH(PW),
    .LANES      (LANES),
    .FRAME_WORDS(FW),
    .CNT_WIDTH  (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .threshold   (threshold),
    .mode        (mode),
    .bus         (bus.slave),
    .frame_done  (frame_done),
    .motion_count(motion_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] data;
    int           pop;
  } result_t;

  // Reference model state.
  result_t pend[$];
  int      m_in_idx, m_out_idx, m_acc, m_thr, m_mode;
  int      exp_count;
  bit      exp_done;
  int      done_seen, pops_seen;
  int      tests, failed;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic result_t ref_word(input logic [W-1:0] bg, input logic [W-1:0] cur,
                                       input int thr, input int md);
    result_t r;
    r.data = '0;
    r.pop  = 0;
    for (int i = 0; i < LANES; i++) begin
      int b, c, d;
      b = int'(bg[i*PW +: PW]);
      c = int'(cur[i*PW +: PW]);
      d = (c > b) ? c - b : b - c;
      if (d > thr) r.pop++;
      if (md != 0) r.data[i*PW +: PW] = d[PW-1:0];
      else         r.data[i*PW +: PW] = (d > thr) ? {PW{1'b1}} : {PW{1'b0}};
    end
    return r;
  endfunction

  task automatic model_clear();
    pend.delete();
    m_in_idx  = 0;
    m_out_idx = 0;
    m_acc     = 0;
    m_thr     = 0;
    m_mode    = 0;
    exp_count = 0;
    exp_done  = 0;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic tick();
    bit      exp_rd, exp_wr, done_next;
    result_t r;
    #1;
    exp_rd = reset && !bus.in_empty && (pend.size() == 0 || !bus.out_full);
    exp_wr = (pend.size() != 0) && !bus.out_full;
    check("in_rd_en", bus.in_rd_en, exp_rd);
    check("out_wr_en", bus.out_wr_en, exp_wr);
    if (pend.size() != 0) check("out_din", bus.out_din, pend[0].data);
    check("frame_done", frame_done, exp_done);
    check("motion_count", motion_count, exp_count);
    if (frame_done === 1'b1) done_seen++;
    if (bus.in_rd_en === 1'b1) pops_seen++;
    done_next = 0;
    if (exp_wr) begin
      r = pend.pop_front();
      m_acc += r.pop;
      m_out_idx++;
      if (m_out_idx == FW) begin
        exp_count = m_acc;
        m_acc     = 0;
        m_out_idx = 0;
        done_next = 1;
      end
    end
    if (exp_rd) begin
      if (m_in_idx == 0) begin
        m_thr  = int'(threshold);
        m_mode = int'(mode);
      end
      pend.push_back(ref_word(bus.in_bg_dout, bus.in_cur_dout, m_thr, m_mode));
      m_in_idx = (m_in_idx + 1) % FW;
    end
    @(posedge clock);
    #1;
    exp_done = done_next;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    bus.in_empty = 1'b0;
    #1;
    check("rst_in_rd_en", bus.in_rd_en, 1'b0);
    check("rst_out_wr_en", bus.out_wr_en, 1'b0);
    check("rst_out_din", bus.out_din, '0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_motion_count", motion_count, '0);
    model_clear();
    @(posedge clock);
    #1;
    bus.in_empty = 1'b1;
    reset        = 1'b1;
  endtask

  task automatic feed(input logic [W-1:0] bg, input logic [W-1:0] cur);
    bus.in_empty    = 1'b0;
    bus.in_bg_dout  = bg;
    bus.in_cur_dout = cur;
    tick();
    bus.in_empty    = 1'b1;
    bus.in_bg_dout  = W'($urandom);
    bus.in_cur_dout = W'($urandom);
  endtask

  task automatic idle(input int n);
    bus.in_empty = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Random word whose first n lanes differ by more than 50 and the rest by at most 50.
  task automatic make_word(input int n, output logic [W-1:0] bg, output logic [W-1:0] cur);
    for (int i = 0; i < LANES; i++) begin
      int b, c;
      b = int'($urandom_range(0, 255));
      if (i < n) c = (b >= 128) ? int'($urandom_range(0, b - 51)) : int'($urandom_range(b + 51, 255));
      else       c = int'($urandom_range((b > 50) ? b - 50 : 0, (b < 205) ? b + 50 : 255));
      bg[i*PW +: PW]  = b[PW-1:0];
      cur[i*PW +: PW] = c[PW-1:0];
    end
  endtask

  initial begin
    logic [W-1:0] bg, cur;
    tests = 0;
    failed = 0;
    done_seen = 0;
    pops_seen = 0;
    threshold = 8'd0;
    mode = 1'b0;
    bus.in_empty = 1'b1;
    bus.out_full = 1'b0;
    bus.in_bg_dout = '0;
    bus.in_cur_dout = '0;
    model_clear();
    @(posedge clock);
    #1;
    do_reset();
    idle(2);

    // Mask mode: diffs 50, 51, 0, 255 with cur > bg, then bg > cur.
    threshold = 8'd50;
    mode = 1'b0;
    feed({8'd0, 8'd100, 8'd10, 8'd0}, {8'd255, 8'd100, 8'd61, 8'd50});
    check("mask_cur_gt_bg", bus.out_din, 32'hFF00_FF00);
    feed({8'd255, 8'd100, 8'd61, 8'd50}, {8'd0, 8'd100, 8'd10, 8'd0});
    check("mask_bg_gt_cur", bus.out_din, 32'hFF00_FF00);
    idle(3);
    check("mask_frame_count", motion_count, 4);

    // Magnitude mode in both directions.
    mode = 1'b1;
    feed({LANES{8'h10}}, {LANES{8'hF0}});
    check("mag_cur_gt_bg", bus.out_din, 32'hE0E0_E0E0);
    feed({LANES{8'hF0}}, {LANES{8'h10}});
    check("mag_bg_gt_cur", bus.out_din, 32'hE0E0_E0E0);
    idle(3);
    check("mag_frame_count", motion_count, 8);

    // Two frames with 3 then 5 motion lanes.
    mode = 1'b0;
    done_seen = 0;
    make_word(2, bg, cur); feed(bg, cur);
    make_word(1, bg, cur); feed(bg, cur);
    idle(3);
    check("frame_a_count", motion_count, 3);
    make_word(4, bg, cur); feed(bg, cur);
    make_word(1, bg, cur); feed(bg, cur);
    idle(3);
    check("frame_b_count", motion_count, 5);
    check("frame_done_pulses", done_seen, 2);

    // Backpressure: output full for 5 cycles with input available.
    bus.out_full = 1'b1;
    bus.in_empty = 1'b0;
    pops_seen = 0;
    for (int i = 0; i < 5; i++) begin
      bus.in_bg_dout  = W'($urandom);
      bus.in_cur_dout = W'($urandom);
      tick();
    end
    check("bp_single_pop", pops_seen, 1);
    check("bp_held_data", bus.out_din, pend[0].data);
    bus.out_full = 1'b0;

    // Random traffic, including mid-frame threshold/mode changes.
    for (int i = 0; i < 80; i++) begin
      bus.in_empty    = ($urandom_range(0, 3) == 0);
      bus.out_full    = ($urandom_range(0, 3) == 0);
      bus.in_bg_dout  = W'($urandom);
      bus.in_cur_dout = W'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        threshold = PW'($urandom);
        mode      = 1'($urandom);
      end
      tick();
    end
    bus.out_full = 1'b0;
    idle(3);
    check("drain_no_push", bus.out_wr_en, 1'b0);
    if (m_in_idx != 0) begin
      make_word(0, bg, cur);
      feed(bg, cur);
    end
    idle(3);

    // Threshold change after word 0 only takes effect at the next frame.
    threshold = 8'd50;
    mode = 1'b0;
    feed({LANES{8'h20}}, {LANES{8'h3E}});
    check("thr_word0", bus.out_din, 32'h0000_0000);
    threshold = 8'd0;
    feed({LANES{8'h20}}, {LANES{8'h3E}});
    check("thr_word1_old", bus.out_din, 32'h0000_0000);
    feed({LANES{8'h20}}, {LANES{8'h3E}});
    check("thr_next_frame", bus.out_din, 32'hFFFF_FFFF);
    feed({LANES{8'h3E}}, {LANES{8'h20}});
    idle(3);
    check("thr_frame_count", motion_count, 8);

    // Reset after one push of a partial frame.
    threshold = 8'd50;
    make_word(4, bg, cur); feed(bg, cur);
    idle(1);
    do_reset();
    make_word(1, bg, cur); feed(bg, cur);
    make_word(1, bg, cur); feed(bg, cur);
    idle(3);
    check("post_reset_count", motion_count, 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
